imem_responder: RTL and testbench



---
 rtl/imem_responder.sv | 118 +++++++++++
 tb/tb_imem_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: validates a fetch address against the text segment
// and returns the word (or an error code) after a fixed latency over valid/ready.
`timescale 1ns/1ps
module imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [31:0]      req_addr,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [31:0]      rsp_inst,
    output logic [1:0]       rsp_err,
    input  logic             rsp_ready,
    input  logic             ld_en,
    input  logic [IDX_W-1:0] ld_idx,
    input  logic [31:0]      ld_data
);

    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS) << 2;
    localparam logic [1:0]  CNT_INIT  = 2'(LATENCY - 1);

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] rsp_inst_q, rsp_inst_d;
    logic [1:0]  rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] offset;
    logic [31:0] lookup_inst;
    logic [1:0]  lookup_err;

    // Memory is intentionally left out of reset so a preloaded image survives rst.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

    // The array read sees pre-edge contents, so a same-edge load returns the old word.
    always_comb begin
        offset      = req_addr - BASE_ADDR;
        lookup_inst = 32'h0000_0000;
        lookup_err  = ERR_OK;
        if (req_addr[1:0] != 2'b00) begin
            lookup_err = ERR_MISALIGN;
        end else if ((req_addr < BASE_ADDR) || (offset >= MEM_BYTES)) begin
            lookup_err = ERR_RANGE;
        end else begin
            lookup_inst = mem[offset[IDX_W+1:2]];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_inst_d = rsp_inst_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rsp_inst_d = lookup_inst;
                    rsp_err_d  = lookup_err;
                    cnt_d      = CNT_INIT;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            rsp_inst_q <= 32'h0000_0000;
            rsp_err_q  <= ERR_OK;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_inst_q <= rsp_inst_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_inst  = rsp_inst_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: three instances (LATENCY 2, 1, 4) share clk/rst;
// stimulus pushes expected responses, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_imem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_3000;

    typedef struct {
        logic [31:0] inst;
        logic [1:0]  err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [3];
    logic [31:0] req_addr  [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_inst  [3];
    logic [1:0]  rsp_err   [3];
    logic        rsp_ready [3];
    logic        ld_en     [3];
    logic [9:0]  ld_idx    [3];
    logic [31:0] ld_data   [3];

    exp_t        exp_q [3][$];
    exp_t        cur [3];
    logic        prev_valid [3];
    logic [31:0] model_mem [3][DEPTH];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        imem_responder #(
            .BASE_ADDR  (BASE),
            .DEPTH_WORDS(DEPTH),
            .LATENCY    (LAT)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .req_valid(req_valid[g]),
            .req_addr (req_addr[g]),
            .req_ready(req_ready[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_inst (rsp_inst[g]),
            .rsp_err  (rsp_err[g]),
            .rsp_ready(rsp_ready[g]),
            .ld_en    (ld_en[g]),
            .ld_idx   (ld_idx[g]),
            .ld_data  (ld_data[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per rising rsp_valid and holds it while valid stays up.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid[i] && !prev_valid[i]) begin
                if (exp_q[i].size() == 0) begin
                    checkOutput($sformatf("unexpected_rsp_dut%0d", i), 32'd1, 32'd0);
                end else begin
                    automatic exp_t e = exp_q[i].pop_front();
                    cur[i] <= e;
                    checkOutput($sformatf("rsp_inst_dut%0d", i), rsp_inst[i], e.inst);
                    checkOutput($sformatf("rsp_err_dut%0d", i), 32'(rsp_err[i]), 32'(e.err));
                    checkOutput($sformatf("latency_dut%0d", i), 32'(cyc - e.acc), 32'(lat_of(i)));
                end
            end else if (rsp_valid[i]) begin
                checkOutput($sformatf("hold_inst_dut%0d", i), rsp_inst[i], cur[i].inst);
                checkOutput($sformatf("hold_err_dut%0d", i), 32'(rsp_err[i]), 32'(cur[i].err));
            end
            prev_valid[i] <= rsp_valid[i];
        end
    end

    task automatic applyStimulus(input int d, input logic [31:0] addr, input logic [31:0] e_inst,
                                 input logic [1:0] e_err, input logic do_ld,
                                 input logic [9:0] idx, input logic [31:0] data);
        automatic int   n = 0;
        automatic exp_t e;
        @(negedge clk);
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) checkOutput($sformatf("req_ready_timeout_dut%0d", d), 32'd0, 32'd1);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        ld_en[d]     = do_ld;
        ld_idx[d]    = idx;
        ld_data[d]   = data;
        @(posedge clk);
        #1;
        e.inst = e_inst;
        e.err  = e_err;
        e.acc  = cyc;
        exp_q[d].push_back(e);
        if (do_ld) model_mem[d][idx] = data;
        req_valid[d] = 1'b0;
        ld_en[d]     = 1'b0;
    endtask

    task automatic loadWord(input int d, input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        ld_en[d]   = 1'b1;
        ld_idx[d]  = idx;
        ld_data[d] = data;
        @(posedge clk);
        #1;
        ld_en[d] = 1'b0;
        model_mem[d][idx] = data;
    endtask

    task automatic waitDrain(input int d);
        automatic int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q[d].size() == 0 && req_ready[d] && !rsp_valid[d]) && n < 40);
        if (n >= 40) checkOutput($sformatf("drain_timeout_dut%0d", d), 32'd0, 32'd1);
    endtask

    task automatic waitValid(input int d);
        automatic int n = 0;
        while (!rsp_valid[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid[d]) checkOutput($sformatf("valid_timeout_dut%0d", d), 32'd0, 32'd1);
    endtask

    task automatic fetch(input int d, input logic [31:0] addr, input logic [31:0] e_inst,
                         input logic [1:0] e_err);
        applyStimulus(d, addr, e_inst, e_err, 1'b0, 10'd0, 32'd0);
        waitDrain(d);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = 32'h0;
            rsp_ready[i] = 1'b1;
            ld_en[i]     = 1'b0;
            ld_idx[i]    = 10'd0;
            ld_data[i]   = 32'h0;
        end

        // Reset values, and a request held during reset must not be taken.
        req_valid[0] = 1'b1;
        req_addr[0]  = BASE;
        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready[0]), 32'd1);
        checkOutput("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        checkOutput("reset_rsp_inst", rsp_inst[0], 32'h0);
        checkOutput("reset_rsp_err", 32'(rsp_err[0]), 32'd0);
        req_valid[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);

        loadWord(0, 10'd0, 32'h2010_0001);
        loadWord(0, 10'd1, 32'h8C09_0004);
        loadWord(0, 10'd3, 32'h1111_1111);

        // Good fetches and the error cases.
        fetch(0, 32'h0000_3000, 32'h2010_0001, 2'b00);
        fetch(0, 32'h0000_3004, 32'h8C09_0004, 2'b00);
        fetch(0, 32'h0000_3002, 32'h0, 2'b01);
        fetch(0, 32'h0000_2FFC, 32'h0, 2'b10);
        fetch(0, 32'h0000_4000, 32'h0, 2'b10);
        fetch(0, 32'h0000_2FFE, 32'h0, 2'b01);

        // Backpressure with ignored request pulses.
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        applyStimulus(0, 32'h0000_3004, 32'h8C09_0004, 2'b00, 1'b0, 10'd0, 32'd0);
        waitValid(0);
        for (int k = 0; k < 5; k++) begin
            req_valid[0] = 1'b1;
            req_addr[0]  = 32'h0000_3000;
            @(posedge clk);
            #1;
            req_valid[0] = 1'b0;
            @(negedge clk);
            checkOutput("bp_req_ready", 32'(req_ready[0]), 32'd0);
            checkOutput("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_consumed_valid", 32'(rsp_valid[0]), 32'd0);
        checkOutput("bp_consumed_ready", 32'(req_ready[0]), 32'd1);
        repeat (6) @(negedge clk);
        checkOutput("bp_no_extra_rsp", 32'(rsp_valid[0]), 32'd0);

        // Same-edge load and accept: old word returned, new word visible afterwards.
        applyStimulus(0, 32'h0000_300C, 32'h1111_1111, 2'b00, 1'b1, 10'd3, 32'h2222_2222);
        waitDrain(0);
        fetch(0, 32'h0000_300C, 32'h2222_2222, 2'b00);

        // Asynchronous reset while BUSY.
        applyStimulus(0, 32'h0000_3000, 32'h2010_0001, 2'b00, 1'b0, 10'd0, 32'd0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_busy_valid", 32'(rsp_valid[0]), 32'd0);
        checkOutput("rst_busy_ready", 32'(req_ready[0]), 32'd1);
        exp_q[0].delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("rst_busy_no_stale", 32'(rsp_valid[0]), 32'd0);

        // Asynchronous reset while RESP.
        rsp_ready[0] = 1'b0;
        applyStimulus(0, 32'h0000_3004, 32'h8C09_0004, 2'b00, 1'b0, 10'd0, 32'd0);
        waitValid(0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_resp_valid", 32'(rsp_valid[0]), 32'd0);
        checkOutput("rst_resp_ready", 32'(req_ready[0]), 32'd1);
        checkOutput("rst_resp_inst", rsp_inst[0], 32'h0);
        exp_q[0].delete();
        @(negedge clk);
        rst = 1'b0;
        rsp_ready[0] = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("rst_resp_no_stale", 32'(rsp_valid[0]), 32'd0);

        // Memory survives reset.
        fetch(0, 32'h0000_3000, 32'h2010_0001, 2'b00);
        fetch(0, 32'h0000_3004, 32'h8C09_0004, 2'b00);
        fetch(0, 32'h0000_300C, 32'h2222_2222, 2'b00);

        // Bulk preload of the LATENCY=1 and LATENCY=4 instances.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            for (int d = 1; d < 3; d++) begin
                ld_en[d]   = 1'b1;
                ld_idx[d]  = 10'(i);
                ld_data[d] = (32'(i) * 32'h9E37_79B1) ^ 32'(d << 28);
                model_mem[d][i] = ld_data[d];
            end
        end
        @(negedge clk);
        ld_en[1] = 1'b0;
        ld_en[2] = 1'b0;

        for (int d = 1; d < 3; d++) begin
            for (int k = 0; k < 20; k++) begin
                automatic int idx = int'($urandom_range(DEPTH - 1, 0));
                fetch(d, BASE + 32'(idx * 4), model_mem[d][idx], 2'b00);
            end
        end

        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("queue_empty_dut%0d", i), 32'(exp_q[i].size()), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
